// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with optional shift-add multiplier (macro ALU_MC_MUL_EN)
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);

`ifdef ALU_MC_MUL_EN
    typedef enum logic [1:0] {IDLE, DONE, MUL} state_t;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    state_t           state, state_n;
    logic             pend, pend_n;
    logic             capture;
    logic             go;
    logic             mul_go;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_s, b_s;
    logic [2:0]       op_s;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] result_n;
    logic             ovf_n;

    // A request taken in DONE is parked in a_q/b_q/op_q and executed on the following cycle
    assign a_s  = pend ? a_q  : a;
    assign b_s  = pend ? b_q  : b;
    assign op_s = pend ? op_q : op;

    // Single-cycle operations and their signed-overflow flag
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        sum     = a_s + b_s;
        diff    = a_s - b_s;
        case (op_s)
            3'b000: begin
                alu_res = sum;
                alu_ovf = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum[WIDTH-1] != a_s[WIDTH-1]);
            end
            3'b100: begin
                alu_res = diff;
                alu_ovf = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (diff[WIDTH-1] != a_s[WIDTH-1]);
            end
            3'b001:  alu_res = a_s & b_s;
            3'b101:  alu_res = a_s | b_s;
            3'b010:  alu_res = a_s ^ b_s;
            3'b110:  alu_res = {b_s[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            3'b111:  alu_res = ($signed(a_s) < $signed(b_s)) ? WIDTH'(1) : '0;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        pend_n   = pend;
        result_n = result;
        ovf_n    = ovf;
        capture  = 1'b0;
        go       = 1'b0;
        mul_go   = 1'b0;
        case (state)
            IDLE: begin
                go     = pend || start;
                pend_n = 1'b0;
            end
            DONE: begin
                state_n = IDLE;
                if (start) begin
                    capture = 1'b1;
                    pend_n  = 1'b1;
                end
            end
`ifdef ALU_MC_MUL_EN
            MUL: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n  = DONE;
                    result_n = acc_next;
                    ovf_n    = 1'b0;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
        if (go) begin
`ifdef ALU_MC_MUL_EN
            if (op_s == 3'b011) begin
                mul_go  = 1'b1;
                state_n = MUL;
            end else begin
                result_n = alu_res;
                ovf_n    = alu_ovf;
                state_n  = DONE;
            end
`else
            result_n = alu_res;
            ovf_n    = alu_ovf;
            state_n  = DONE;
`endif
        end
    end

    // State, parked request and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            result <= '0;
            zero   <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            state  <= state_n;
            pend   <= pend_n;
            result <= result_n;
            zero   <= (result_n == '0);
            ovf    <= ovf_n;
            if (capture) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
            end
        end
    end

`ifdef ALU_MC_MUL_EN
    // Shift-add multiplier: one multiplier bit per cycle, LSB first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (mul_go) begin
            mcand  <= a_s;
            mplier <= b_s;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    assign busy = (state == MUL);
`else
    assign busy = 1'b0;
`endif

    assign done = (state == DONE);

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized self-checking bench for alu_mc against an arithmetic model
module tb_alu_mc;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         busy, done, zero, ovf;
    logic [W-1:0] result;

    int errors = 0;
    int checks = 0;

`ifdef ALU_MC_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
        .busy(busy), .done(done), .result(result), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: true-value arithmetic, overflow when the wrapped result's signed value differs
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic v);
        longint sx, sy, s;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        v  = 1'b0;
        r  = '0;
        case (o)
            3'd0: begin s = sx + sy; r = W'(s); v = (s != longint'($signed(r))); end
            3'd4: begin s = sx - sy; r = W'(s); v = (s != longint'($signed(r))); end
            3'd1: r = x & y;
            3'd5: r = x | y;
            3'd2: r = x ^ y;
            3'd6: r = W'((longint'(y) % 65536) * 65536);
            3'd7: r = (sx < sy) ? 1 : 0;
            default: begin
                p = {32'd0, x} * {32'd0, y};
                r = MUL_ON ? p[W-1:0] : '0;
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic v;
        int lat, bcnt, exp_lat;
        model(o, x, y, r, v);
        exp_lat = (MUL_ON && o == 3'b011) ? W + 1 : 1;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            start = busy && ($urandom_range(0, 3) == 0);
            a = $urandom; b = $urandom; op = 3'($urandom);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".busycyc"}, bcnt, exp_lat - 1);
        check({tag, ".res"}, result, r);
        check({tag, ".zero"}, zero, (r == 0));
        check({tag, ".ovf"}, ovf, v);
        @(negedge clk);
        check({tag, ".donepulse"}, done, 0);
        check({tag, ".hold"}, result, r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] rx, ry;
        logic [2:0] ro;
        bit saw;

        repeat (2) @(negedge clk);
        check("rst.result", result, 0);
        check("rst.zero", zero, 1);
        check("rst.ovf", ovf, 0);
        check("rst.done", done, 0);
        check("rst.busy", busy, 0);

        // Release reset and request in the same cycle: accepted on the first edge
        @(negedge clk);
        rst = 1'b0; start = 1'b1; op = 3'b000; a = 32'h7FFF_FFFF; b = 32'h1;
        @(negedge clk);
        start = 1'b0;
        check("addovf.done", done, 1);
        check("addovf.res", result, 32'h8000_0000);
        check("addovf.ovf", ovf, 1);
        check("addovf.zero", zero, 0);
        @(negedge clk);
        check("addovf.donepulse", done, 0);

        run_op("sub0", 3'b100, 32'd5, 32'd5);
        run_op("slt", 3'b111, 32'hFFFF_FFFF, 32'd1);
        run_op("mul", 3'b011, 32'h0001_0001, 32'h3);
        run_op("shl", 3'b110, 32'h0, 32'h1234_ABCD);
        check("shl.const", result, 32'hABCD_0000);
        run_op("subovf", 3'b100, 32'h8000_0000, 32'h1);

        // Back-to-back: second request taken in DONE, completes two cycles later
        @(negedge clk);
        start = 1'b1; op = 3'b001; a = 32'hF0F0_F0F0; b = 32'h0FF0_0FF0;
        @(negedge clk);
        check("b2b.done1", done, 1);
        check("b2b.res1", result, 32'h00F0_00F0);
        op = 3'b101;
        @(negedge clk);
        start = 1'b0;
        check("b2b.gap", done, 0);
        @(negedge clk);
        check("b2b.done2", done, 1);
        check("b2b.res2", result, 32'hFFF0_FFF0);
        @(negedge clk);
        check("b2b.idle", done, 0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; op = MUL_ON ? 3'b011 : 3'b101; a = 32'hDEAD_BEEF; b = 32'h0000_0F0F;
        @(negedge clk);
        start = 1'b0;
        if (MUL_ON) begin
            repeat (9) @(negedge clk);
            check("arst.busybefore", busy, 1);
        end
        #2 rst = 1'b1;
        #1;
        check("arst.result", result, 0);
        check("arst.zero", zero, 1);
        check("arst.ovf", ovf, 0);
        check("arst.busy", busy, 0);
        check("arst.done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        check("arst.nodone", saw, 0);
        run_op("postrst", 3'b110, 32'h0, 32'h1234_ABCD);

        // Random operations with corner operands mixed in
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: rx = 32'h7FFF_FFFF;
                1: rx = 32'h8000_0000;
                2: rx = 32'h0;
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: ry = 32'hFFFF_FFFF;
                1: ry = 32'h8000_0000;
                2: ry = rx;
                default: ry = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), ro, rx, ry);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; even, >= 8.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 start  in  1  request; sampled on rising clk; accepted only when busy=0.
REQ-005 a  in  WIDTH  operand A, captured on accepted start.
REQ-006 b  in  WIDTH  operand B, captured on accepted start.
REQ-007 op  in  3  operation code, captured on accepted start.
REQ-008 busy  out  1  high while a multi-cycle operation is in progress.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 result  out  WIDTH  registered result; holds until the next completion.
REQ-011 zero  out  1  high when result == 0; updates with result.
REQ-012 ovf  out  1  signed overflow for add/sub; 0 for all other ops.

Function
REQ-013 Op codes: 000 a+b; 100 a-b; 001 a&b; 101 a|b; 010 a^b; 110 {b[WIDTH/2-1:0], WIDTH/2 zeros}; 111 signed a<b -> 1 else 0; 011 multiply (REQ-021).
REQ-014 Add/sub wrap modulo 2^WIDTH; carry-out discarded.
REQ-015 ovf = operand sign bits equal (add) / differ (sub) and result sign differs from a's sign.
REQ-016 FSM states: IDLE, MUL, DONE.
REQ-017 IDLE + start with single-cycle op: result/zero/ovf registered at that edge; next state DONE.
REQ-018 DONE: done=1 for exactly that cycle; busy=0; start accepted there under the same rules as IDLE (back-to-back issue, one result per 2 cycles).
REQ-019 DONE without start -> IDLE; done=0 in IDLE and MUL.
REQ-020 start while busy=1 is ignored; captured operands and op do not change.
REQ-021 Multiply: unsigned shift-add, one multiplier bit per cycle, LSB first; result = low WIDTH bits of a*b; state MUL for exactly WIDTH cycles; then DONE; start-to-done latency WIDTH+1 cycles.
REQ-022 busy=1 exactly during MUL; result/zero/ovf keep previous values until the MUL->DONE edge.
REQ-023 Undefined op (011 with macro off): result=0, zero=1, ovf=0, single-cycle path.
REQ-024 zero derived from the registered result, never from a stale or partial product.

Reset
REQ-025 rst=1 forces, without clock: state IDLE, result=0, zero=1, ovf=0, done=0, busy=0, multiply accumulator and counter=0.
REQ-026 rst during MUL aborts the operation; no done pulse follows release.
REQ-027 First start after rst release is accepted on the first rising clk with rst=0.

Configuration
REQ-028 Macro ALU_MC_MUL_EN: defined -> op 011 multiplies per REQ-021, MUL state and datapath present.
REQ-029 ALU_MC_MUL_EN undefined -> op 011 follows REQ-023, MUL state and multiplier logic absent, busy tied 0.

Verification (WIDTH=32)
REQ-030 start, op=000, a=0x7FFFFFFF, b=1 -> next cycle done=1, result=0x80000000, ovf=1, zero=0.
REQ-031 start, op=100, a=5, b=5 -> result=0, zero=1, ovf=0; op=111, a=0xFFFFFFFF, b=1 -> result=1.
REQ-032 Macro on: start, op=011, a=0x00010001, b=0x00000003 -> busy 32 cycles, done on cycle 33, result=0x00030003; start pulses during busy ignored.
REQ-033 Macro on: assert rst at MUL cycle 10 -> outputs at reset values immediately, no done after release; next op=110, b=0x1234ABCD -> result=0xABCD0000.
REQ-034 Back-to-back: start held high with op=001 then op=101 (a=0xF0F0F0F0, b=0x0FF00FF0) -> done pulses in alternating cycles, results 0x00F000F0 then 0xFFF0FFF0.
REQ-035 Macro off: start, op=011, a=3, b=4 -> 1-cycle done, result=0, zero=1, busy never high.
